// File: rtl/alu_shift_seq_if.sv
// Bundle between the execute stage, the shift sequencer and the ALU.
//   Request side  : start, op_in, val_in, cnt_in, fi_in     (execute -> sequencer)
//   Response side : busy, done, err, res_out, fo_out        (sequencer -> execute)
//   ALU side      : alu_op, alu_di, alu_fi                  (sequencer -> ALU)
//                   alu_res, alu_fo                         (ALU -> sequencer, combinational)
// master = environment (execute stage plus ALU), slave = the sequencer.
interface alu_shift_seq_if #(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = 6
);
    logic              start;
    logic [5:0]        op_in;
    logic [WIDTH-1:0]  val_in;
    logic [CWIDTH-1:0] cnt_in;
    logic [7:0]        fi_in;
    logic              busy;
    logic              done;
    logic              err;
    logic [WIDTH-1:0]  res_out;
    logic [7:0]        fo_out;
    logic [5:0]        alu_op;
    logic [WIDTH-1:0]  alu_di;
    logic [7:0]        alu_fi;
    logic [WIDTH-1:0]  alu_res;
    logic [7:0]        alu_fo;

    modport master (
        output start, op_in, val_in, cnt_in, fi_in, alu_res, alu_fo,
        input  busy, done, err, res_out, fo_out, alu_op, alu_di, alu_fi
    );

    modport slave (
        input  start, op_in, val_in, cnt_in, fi_in, alu_res, alu_fo,
        output busy, done, err, res_out, fo_out, alu_op, alu_di, alu_fi
    );
endinterface

// File: rtl/alu_shift_seq.sv
// Shift-by-N sequencer: steps the ALU's single-bit shift/rotate ops N times,
// feeding the ALU's result and flags back into it every cycle.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high reset
//   bus   - alu_shift_seq_if.slave: request (start/op_in/val_in/cnt_in/fi_in),
//           response (busy/done/err/res_out/fo_out), ALU drive and return.
//
// state | meaning
// IDLE  | waiting for start; request is captured on acceptance
// RUN   | one ALU step per cycle, counter decrements, exits when it reaches 1
// DONE  | one-cycle done pulse (err too if the op was illegal), back to IDLE
module alu_shift_seq #(
    parameter int WIDTH  = 32,
    parameter int CWIDTH = 6
) (
    input logic         clk,
    input logic         reset,
    alu_shift_seq_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    state_t            w_next;
    logic [5:0]        r_op;
    logic [WIDTH-1:0]  r_val;
    logic [7:0]        r_flg;
    logic [WIDTH-1:0]  r_res;
    logic [7:0]        r_fo;
    logic [CWIDTH-1:0] r_cnt;
    logic              r_err;
    logic              w_legal;
    logic              w_accept;
    logic              w_last;
    logic              w_skip;

    assign w_legal  = (bus.op_in >= 6'h26) && (bus.op_in <= 6'h2a);
    assign w_accept = (r_state == S_IDLE) && bus.start;
    assign w_last   = (r_cnt == CWIDTH'(1));
    // Illegal ops and zero counts never step the ALU.
    assign w_skip   = !w_legal || (bus.cnt_in == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_next = w_skip ? S_DONE : S_RUN;
            S_RUN:   if (w_last)    w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        bus.err  = 1'b0;
        case (r_state)
            S_RUN:  bus.busy = 1'b1;
            S_DONE: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
                bus.err  = r_err;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op  <= '0;
            r_val <= '0;
            r_flg <= '0;
            r_res <= '0;
            r_fo  <= '0;
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    // An illegal op is replaced by a harmless rotate so the ALU
                    // never sees a write-capable opcode.
                    r_op  <= w_legal ? bus.op_in : 6'h26;
                    r_val <= bus.val_in;
                    r_flg <= bus.fi_in;
                    r_cnt <= bus.cnt_in;
                    r_err <= !w_legal;
                    if (w_skip) begin
                        r_res <= bus.val_in;
                        r_fo  <= bus.fi_in;
                    end
                end
                S_RUN: begin
                    r_val <= bus.alu_res;
                    r_flg <= bus.alu_fo;
                    r_cnt <= r_cnt - CWIDTH'(1);
                    // Outputs update only with the last step so they hold the
                    // previous result while a new operation is running.
                    if (w_last) begin
                        r_res <= bus.alu_res;
                        r_fo  <= bus.alu_fo;
                    end
                end
                S_DONE: r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    assign bus.res_out = r_res;
    assign bus.fo_out  = r_fo;
    assign bus.alu_op  = r_op;
    assign bus.alu_di  = r_val;
    assign bus.alu_fi  = r_flg;
endmodule

// File: tb/tb_alu_shift_seq.sv
module tb_alu_shift_seq;
    localparam int CIDX = 0;
    localparam int ZIDX = 6;
    localparam int SIDX = 7;

    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    int          t_lat;
    logic [31:0] t_res;
    logic [7:0]  t_fo;
    logic        t_err;
    logic [5:0]  t_aop;

    alu_shift_seq_if #(.WIDTH(32), .CWIDTH(6)) ifc ();

    alu_shift_seq #(.WIDTH(32), .CWIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: single-bit shifts, rotates through carry.
    logic [31:0] m_res;
    logic [7:0]  m_fo;
    logic        m_c;
    always_comb begin
        m_res = ifc.alu_di;
        m_fo  = ifc.alu_fi;
        m_c   = ifc.alu_fi[CIDX];
        case (ifc.alu_op)
            6'h26: begin m_res = {ifc.alu_fi[CIDX], ifc.alu_di[31:1]}; m_c = ifc.alu_di[0]; end
            6'h27: {m_c, m_res} = {ifc.alu_di, ifc.alu_fi[CIDX]};
            6'h28: {m_c, m_res} = {ifc.alu_di, 1'b0};
            6'h29: begin m_res = {1'b0, ifc.alu_di[31:1]}; m_c = ifc.alu_di[0]; end
            6'h2a: begin m_res = {ifc.alu_di[31], ifc.alu_di[31:1]}; m_c = ifc.alu_di[0]; end
            default: ;
        endcase
        m_fo[CIDX] = m_c;
        m_fo[ZIDX] = (m_res == 32'h0);
        m_fo[SIDX] = m_res[31];
    end
    assign ifc.alu_res = m_res;
    assign ifc.alu_fo  = m_fo;

    // Issue one request and wait (bounded) for done; leaves us #1 after the done edge.
    task automatic run_op(input logic [5:0] op, input logic [31:0] val,
                          input logic [5:0] cnt, input logic [7:0] fi);
        int guard = 0;
        @(negedge clk);
        while (ifc.busy && guard < 100) begin @(negedge clk); guard++; end
        ifc.start = 1'b1; ifc.op_in = op; ifc.val_in = val; ifc.cnt_in = cnt; ifc.fi_in = fi;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        t_lat = 1;
        while (!ifc.done && t_lat < 100) begin @(posedge clk); #1; t_lat++; end
        t_res = ifc.res_out; t_fo = ifc.fo_out; t_err = ifc.err; t_aop = ifc.alu_op;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ifc.start = 1'b0; ifc.op_in = '0; ifc.val_in = '0; ifc.cnt_in = '0; ifc.fi_in = '0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (ifc.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", ifc.busy); end
        n_tests++; if (ifc.done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", ifc.done); end
        n_tests++; if (ifc.err !== 1'b0)    begin n_fail++; $display("FAIL reset_err got %b want 0", ifc.err); end
        n_tests++; if (ifc.res_out !== 32'h0) begin n_fail++; $display("FAIL reset_res got %h want 0", ifc.res_out); end
        n_tests++; if (ifc.fo_out !== 8'h0) begin n_fail++; $display("FAIL reset_fo got %h want 0", ifc.fo_out); end
        n_tests++; if (ifc.alu_op !== 6'h0) begin n_fail++; $display("FAIL reset_alu_op got %h want 0", ifc.alu_op); end
        n_tests++; if (ifc.alu_di !== 32'h0) begin n_fail++; $display("FAIL reset_alu_di got %h want 0", ifc.alu_di); end
        n_tests++; if (ifc.alu_fi !== 8'h0) begin n_fail++; $display("FAIL reset_alu_fi got %h want 0", ifc.alu_fi); end
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic [31:0] val;
        logic [5:0]  cnt;
        logic [7:0]  fi;
        logic [31:0] res;
        logic [7:0]  fo;
        int          lat;
    } vec_t;

    task automatic test_shifts();
        vec_t v [9];
        v[0] = '{6'h28, 32'h0000_0001, 6'd4,  8'h00, 32'h0000_0010, 8'h00, 5};
        v[1] = '{6'h28, 32'h8000_0001, 6'd1,  8'h00, 32'h0000_0002, 8'h01, 2};
        v[2] = '{6'h29, 32'h8000_0000, 6'd31, 8'h00, 32'h0000_0001, 8'h00, 32};
        v[3] = '{6'h2a, 32'h8000_0000, 6'd4,  8'h00, 32'hF800_0000, 8'h80, 5};
        v[4] = '{6'h26, 32'h1234_5678, 6'd33, 8'h3C, 32'h1234_5678, 8'h3C, 34};
        v[5] = '{6'h27, 32'h8000_0000, 6'd2,  8'h00, 32'h0000_0001, 8'h00, 3};
        v[6] = '{6'h28, 32'h0000_0001, 6'd32, 8'h00, 32'h0000_0000, 8'h41, 33};
        v[7] = '{6'h26, 32'h0000_0001, 6'd1,  8'h01, 32'h8000_0000, 8'h81, 2};
        v[8] = '{6'h29, 32'hFFFF_FFFF, 6'd63, 8'h00, 32'h0000_0000, 8'h40, 64};
        for (int i = 0; i < 9; i++) begin
            run_op(v[i].op, v[i].val, v[i].cnt, v[i].fi);
            n_tests++; if (t_lat !== v[i].lat) begin n_fail++; $display("FAIL shift%0d_latency got %0d want %0d", i, t_lat, v[i].lat); end
            n_tests++; if (t_res !== v[i].res) begin n_fail++; $display("FAIL shift%0d_res got %h want %h", i, t_res, v[i].res); end
            n_tests++; if (t_fo !== v[i].fo)   begin n_fail++; $display("FAIL shift%0d_fo got %h want %h", i, t_fo, v[i].fo); end
            n_tests++; if (t_err !== 1'b0)     begin n_fail++; $display("FAIL shift%0d_err got %b want 0", i, t_err); end
        end
    endtask

    task automatic test_zero_count();
        run_op(6'h28, 32'hDEAD_BEEF, 6'd0, 8'h0F);
        n_tests++; if (t_lat !== 1)            begin n_fail++; $display("FAIL zero_latency got %0d want 1", t_lat); end
        n_tests++; if (t_res !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL zero_res got %h want deadbeef", t_res); end
        n_tests++; if (t_fo !== 8'h0F)         begin n_fail++; $display("FAIL zero_fo got %h want 0f", t_fo); end
        n_tests++; if (t_err !== 1'b0)         begin n_fail++; $display("FAIL zero_err got %b want 0", t_err); end
    endtask

    task automatic test_illegal_op();
        run_op(6'h04, 32'hCAFE_F00D, 6'd5, 8'hA5);
        n_tests++; if (t_lat !== 1)            begin n_fail++; $display("FAIL illegal_latency got %0d want 1", t_lat); end
        n_tests++; if (t_err !== 1'b1)         begin n_fail++; $display("FAIL illegal_err got %b want 1", t_err); end
        n_tests++; if (t_res !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL illegal_res got %h want cafef00d", t_res); end
        n_tests++; if (t_fo !== 8'hA5)         begin n_fail++; $display("FAIL illegal_fo got %h want a5", t_fo); end
        n_tests++; if (t_aop !== 6'h26)        begin n_fail++; $display("FAIL illegal_alu_op got %h want 26", t_aop); end
        @(posedge clk); #1;
        n_tests++; if (ifc.err !== 1'b0)  begin n_fail++; $display("FAIL illegal_err_pulse got %b want 0", ifc.err); end
        n_tests++; if (ifc.done !== 1'b0) begin n_fail++; $display("FAIL illegal_done_pulse got %b want 0", ifc.done); end
    endtask

    task automatic test_start_during_run();
        int guard = 0;
        @(negedge clk);
        while (ifc.busy && guard < 100) begin @(negedge clk); guard++; end
        ifc.start = 1'b1; ifc.op_in = 6'h28; ifc.val_in = 32'h1; ifc.cnt_in = 6'd8; ifc.fi_in = 8'h00;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        t_lat = 1;
        n_tests++; if (ifc.busy !== 1'b1)  begin n_fail++; $display("FAIL run_busy got %b want 1", ifc.busy); end
        n_tests++; if (ifc.alu_op !== 6'h28) begin n_fail++; $display("FAIL run_alu_op got %h want 28", ifc.alu_op); end
        repeat (2) begin @(posedge clk); #1; t_lat++; end
        @(negedge clk);
        ifc.start = 1'b1; ifc.op_in = 6'h27; ifc.val_in = 32'h0000_FFFF; ifc.cnt_in = 6'd1; ifc.fi_in = 8'hFF;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        t_lat++;
        while (!ifc.done && t_lat < 100) begin @(posedge clk); #1; t_lat++; end
        n_tests++; if (t_lat !== 9)              begin n_fail++; $display("FAIL run_latency got %0d want 9", t_lat); end
        n_tests++; if (ifc.res_out !== 32'h100)  begin n_fail++; $display("FAIL run_res got %h want 00000100", ifc.res_out); end
        n_tests++; if (ifc.fo_out !== 8'h00)     begin n_fail++; $display("FAIL run_fo got %h want 00", ifc.fo_out); end
    endtask

    task automatic test_start_in_done();
        run_op(6'h28, 32'h1, 6'd1, 8'h00);
        @(negedge clk);
        ifc.start = 1'b1; ifc.op_in = 6'h28; ifc.val_in = 32'h5; ifc.cnt_in = 6'd0; ifc.fi_in = 8'h00;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        n_tests++; if (ifc.busy !== 1'b0)   begin n_fail++; $display("FAIL done_start_busy got %b want 0", ifc.busy); end
        n_tests++; if (ifc.done !== 1'b0)   begin n_fail++; $display("FAIL done_start_done got %b want 0", ifc.done); end
        @(posedge clk); #1;
        n_tests++; if (ifc.done !== 1'b0)   begin n_fail++; $display("FAIL done_start_late got %b want 0", ifc.done); end
        n_tests++; if (ifc.res_out !== 32'h2) begin n_fail++; $display("FAIL done_start_res got %h want 00000002", ifc.res_out); end
    endtask

    task automatic test_reset_mid_run();
        int guard = 0;
        int pulses = 0;
        @(negedge clk);
        while (ifc.busy && guard < 100) begin @(negedge clk); guard++; end
        ifc.start = 1'b1; ifc.op_in = 6'h28; ifc.val_in = 32'h1; ifc.cnt_in = 6'd10; ifc.fi_in = 8'h00;
        @(posedge clk); #1;
        ifc.start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_tests++; if (ifc.alu_di !== 32'h8) begin n_fail++; $display("FAIL midrun_value got %h want 00000008", ifc.alu_di); end
        reset = 1'b1;
        #1;
        n_tests++; if (ifc.busy !== 1'b0)    begin n_fail++; $display("FAIL midrun_busy got %b want 0", ifc.busy); end
        n_tests++; if (ifc.done !== 1'b0)    begin n_fail++; $display("FAIL midrun_done got %b want 0", ifc.done); end
        n_tests++; if (ifc.res_out !== 32'h0) begin n_fail++; $display("FAIL midrun_res got %h want 0", ifc.res_out); end
        n_tests++; if (ifc.alu_di !== 32'h0) begin n_fail++; $display("FAIL midrun_alu_di got %h want 0", ifc.alu_di); end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (ifc.done || ifc.busy) pulses++;
        end
        n_tests++; if (pulses !== 0) begin n_fail++; $display("FAIL midrun_no_done got %0d active cycles want 0", pulses); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_shifts();
        test_zero_count();
        test_illegal_op();
        test_start_during_run();
        test_start_in_done();
        test_reset_mid_run();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
